blink_frequency_meter: RTL and testbench
========================================

Name: blink_frequency_meter

Overview:
- Receive-side counterpart of the blink/frequency generator: samples an external square wave (typically a generator's freqOut looped back) and measures its half-period in clk cycles.
- Compares each measurement against the expected count and reports in-range, lock and loss-of-signal status.
- Used as a self-check monitor next to the generator on the FPGA.

Parameters:
BASE_CLK, 50000000, FPGA base clock frequency in Hz (informational, used only to derive defaults)
TARGET_FREQUENCY, 1, expected input frequency in Hz
MAXIMUM_VALUE, 25000000, expected half-period in clk cycles (BASE_CLK/(2*TARGET_FREQUENCY))
TOLERANCE, 1000, allowed absolute deviation from MAXIMUM_VALUE, in cycles
LOCK_COUNT, 4, consecutive in-range measurements required to assert locked (>=1)
TIMEOUT_VALUE, 100000000, cycles without an edge before timeout is declared (> MAXIMUM_VALUE+TOLERANCE)
NBITS_FOR_COUNTER, 27, counter/halfPeriod width; must hold TIMEOUT_VALUE

Ports:
clk  input  1  internal clock
reset  input  1  asynchronous active-low reset
start  input  1  enable; low forces IDLE
sigIn  input  1  asynchronous square wave under measurement
halfPeriod  output  NBITS_FOR_COUNTER  last measured half-period, cycles
valid  output  1  one-cycle pulse when halfPeriod updates
inRange  output  1  last measurement within MAXIMUM_VALUE +/- TOLERANCE
locked  output  1  LOCK_COUNT consecutive in-range measurements seen
timeout  output  1  no edge for TIMEOUT_VALUE cycles

Behaviour:
- Reset (reset=0, async): all outputs 0, synchronizer flops 0, counter 0, lock counter 0, FSM=IDLE. Reset mid-measurement discards everything; no valid pulse is generated from a partial interval.
- Input path: 2-flop synchronizer (s1,s2) plus a delay flop s3. edge = s2 ^ s3, both polarities. An sigIn transition sampled at clock k produces edge in cycle k+2.
- FSM states:
  - IDLE: counter held at 0. Go to WAIT_EDGE when start=1.
  - WAIT_EDGE: counter increments. On edge: counter<=0, go to MEASURE, no valid.
  - MEASURE: counter increments (saturating at 2**N-1). On edge: halfPeriod<=counter+1, so an edge in cycle a followed by an edge in cycle b gives b-a. In the same cycle: valid<=1 for one cycle, inRange updated, counter<=0, stay in MEASURE.
- start=0 in any state: next cycle FSM=IDLE; counter, lock counter, valid, locked and timeout cleared; halfPeriod and inRange hold.
- inRange: registered with valid; 1 iff |halfPeriod_new - MAXIMUM_VALUE| <= TOLERANCE. Compute with unsigned compare, no wrap: lower bound clamps at 0 if TOLERANCE > MAXIMUM_VALUE.
- Lock counter:
  - In-range measurement increments it, saturating at LOCK_COUNT.
  - Out-of-range measurement or timeout clears it to 0.
  - locked = (lockCnt == LOCK_COUNT), registered; it asserts in the same cycle as the valid pulse of the LOCK_COUNT-th good measurement.
- Timeout: in WAIT_EDGE or MEASURE, when the counter reaches TIMEOUT_VALUE-1 with no edge:
  - timeout<=1, locked<=0, lock counter<=0, counter<=0, FSM->WAIT_EDGE.
  - No valid pulse.
  - timeout is sticky until the next detected edge or start=0; the edge clearing it is treated as the first edge (no measurement).
- Simultaneous edge and timeout threshold in the same cycle: the edge wins (normal measurement, no timeout).
- Constant sigIn: no edges, so the first timeout comes TIMEOUT_VALUE cycles after entering WAIT_EDGE.

Test Plan (override: MAXIMUM_VALUE=10, TOLERANCE=1, LOCK_COUNT=3, TIMEOUT_VALUE=40, NBITS_FOR_COUNTER=8):
- Reset low, sigIn toggling: all outputs 0. Release reset at a non-clock-edge time (t=5 with 4-unit clock period), start=1 -> first edge gives no valid; each following edge gives valid.
- sigIn toggled every 10 clocks -> valid pulses 10 cycles apart, halfPeriod=10, inRange=1; locked rises with the 3rd valid.
- Lock break and saturation:
  - Half-periods 10,10,10,13 -> locked=1 after the 3rd; on the 4th, halfPeriod=13, inRange=0, locked=0.
  - Then 9,11,10 -> locked=1 again.
  - Boundaries: 9 and 11 are in range; 8 and 12 are out of range.
- Loss of signal: sigIn stuck after lock -> timeout=1 and locked=0 exactly 40 cycles after the last edge; next edge clears timeout with no valid; the following edge 10 cycles later gives valid, halfPeriod=10.
- start=0 mid-measurement for 1 cycle -> locked, timeout and valid go 0 and halfPeriod holds. After start=1, the first edge does not measure and the second edge measures.
- Reset asserted 5 cycles into a half-period while locked -> all outputs 0 immediately (asynchronous). After release, measurement restarts from WAIT_EDGE.

Source files
------------

// File: rtl/blink_frequency_meter_if.sv
// rtl/blink_frequency_meter_if.sv - stimulus/status bundle between a square-wave source and the meter
interface blink_frequency_meter_if #(
  parameter int NBITS_FOR_COUNTER = 27
);
  logic                         start;
  logic                         sigIn;
  logic [NBITS_FOR_COUNTER-1:0] halfPeriod;
  logic                         valid;
  logic                         inRange;
  logic                         locked;
  logic                         timeout;

  modport master (
    output start, sigIn,
    input  halfPeriod, valid, inRange, locked, timeout
  );

  modport slave (
    input  start, sigIn,
    output halfPeriod, valid, inRange, locked, timeout
  );
endinterface

// File: rtl/blink_frequency_meter.sv
// rtl/blink_frequency_meter.sv - measures the half-period of a looped-back square wave
// and reports in-range, lock and loss-of-signal status.
module blink_frequency_meter #(
  parameter int BASE_CLK          = 50000000,
  parameter int TARGET_FREQUENCY  = 1,
  parameter int MAXIMUM_VALUE     = BASE_CLK / (2 * TARGET_FREQUENCY),
  parameter int TOLERANCE         = 1000,
  parameter int LOCK_COUNT        = 4,
  parameter int TIMEOUT_VALUE     = 100000000,
  parameter int NBITS_FOR_COUNTER = 27
) (
  input  logic                    clk,
  input  logic                    reset,
  blink_frequency_meter_if.slave  bus
);
  localparam int N   = NBITS_FOR_COUNTER;
  localparam int LCW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

  localparam logic [N-1:0]   CNT_MAX    = {N{1'b1}};
  localparam logic [N-1:0]   TIMEOUT_M1 = N'(TIMEOUT_VALUE - 1);
  localparam logic [LCW-1:0] LOCK_C     = LCW'(LOCK_COUNT);
  localparam logic [63:0]    HI_BOUND   = 64'(MAXIMUM_VALUE) + 64'(TOLERANCE);
  localparam logic [63:0]    LO_BOUND   = (TOLERANCE > MAXIMUM_VALUE) ? 64'd0
                                          : 64'(MAXIMUM_VALUE - TOLERANCE);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEASURE   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           s1_q, s2_q, s3_q;
  logic [N-1:0]   cnt_q, cnt_d;
  logic [N-1:0]   half_q, half_d;
  logic           valid_q, valid_d;
  logic           in_range_q, in_range_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           locked_q, locked_d;
  logic           timeout_q, timeout_d;

  logic           sig_edge;
  logic [N-1:0]   cnt_inc;
  logic           meas_ok;

  // Either polarity of the synchronized input marks a half-period boundary.
  assign sig_edge = s2_q ^ s3_q;
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign meas_ok  = (64'(cnt_inc) >= LO_BOUND) && (64'(cnt_inc) <= HI_BOUND);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.sigIn;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      half_q     <= '0;
      valid_q    <= 1'b0;
      in_range_q <= 1'b0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      valid_q    <= valid_d;
      in_range_q <= in_range_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    half_d     = half_q;
    valid_d    = 1'b0;
    in_range_d = in_range_q;
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    timeout_d  = timeout_q;

    if (!bus.start) begin
      state_d    = IDLE;
      cnt_d      = '0;
      lock_cnt_d = '0;
      locked_d   = 1'b0;
      timeout_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = WAIT_EDGE;
        end

        WAIT_EDGE: begin
          // An edge here (including the one ending a timeout) only arms the measurement.
          if (sig_edge) begin
            cnt_d     = '0;
            timeout_d = 1'b0;
            state_d   = MEASURE;
          end else if (cnt_q == TIMEOUT_M1) begin
            cnt_d      = '0;
            timeout_d  = 1'b1;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        MEASURE: begin
          // Edge takes priority over the timeout threshold in the same cycle.
          if (sig_edge) begin
            half_d     = cnt_inc;
            valid_d    = 1'b1;
            in_range_d = meas_ok;
            cnt_d      = '0;
            if (meas_ok) begin
              lock_cnt_d = (lock_cnt_q >= LOCK_C) ? LOCK_C : lock_cnt_q + 1'b1;
            end else begin
              lock_cnt_d = '0;
            end
            locked_d = (lock_cnt_d == LOCK_C);
          end else if (cnt_q == TIMEOUT_M1) begin
            cnt_d      = '0;
            timeout_d  = 1'b1;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
            state_d    = WAIT_EDGE;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.halfPeriod = half_q;
  assign bus.valid      = valid_q;
  assign bus.inRange    = in_range_q;
  assign bus.locked     = locked_q;
  assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_blink_frequency_meter.sv
// tb/tb_blink_frequency_meter.sv - directed self-checking bench for blink_frequency_meter
`timescale 1ns/1ns
module tb_blink_frequency_meter;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  blink_frequency_meter_if #(.NBITS_FOR_COUNTER(8)) bus ();

  blink_frequency_meter #(
    .MAXIMUM_VALUE    (10),
    .TOLERANCE        (1),
    .LOCK_COUNT       (3),
    .TIMEOUT_VALUE    (40),
    .NBITS_FOR_COUNTER(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #2 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".halfPeriod"}, 32'(bus.halfPeriod), 0);
    check({tag, ".valid"},      32'(bus.valid),      0);
    check({tag, ".inRange"},    32'(bus.inRange),    0);
    check({tag, ".locked"},     32'(bus.locked),     0);
    check({tag, ".timeout"},    32'(bus.timeout),    0);
  endtask

  // Toggles sigIn `gap` clocks after the previous toggle; the resulting edge
  // reaches the status registers on the third clock after the toggle.
  task automatic next_edge(input string tag, input int gap, input bit ev, input int hp,
                           input bit inr, input bit lk, input bit to);
    repeat (gap - 3) tick();
    bus.sigIn = ~bus.sigIn;
    tick();
    tick();
    check({tag, ".pre_valid"}, 32'(bus.valid), 0);
    tick();
    check({tag, ".valid"}, 32'(bus.valid), 32'(ev));
    if (ev) begin
      check({tag, ".halfPeriod"}, 32'(bus.halfPeriod), 32'(hp));
      check({tag, ".inRange"},    32'(bus.inRange),    32'(inr));
    end
    check({tag, ".locked"},  32'(bus.locked),  32'(lk));
    check({tag, ".timeout"}, 32'(bus.timeout), 32'(to));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.start = 1'b0;
    bus.sigIn = 1'b0;

    #3;
    check_all_zero("reset");
    bus.sigIn = 1'b1;
    #1;
    bus.sigIn = 1'b0;
    #1;
    reset     = 1'b1;
    bus.start = 1'b1;
    tick();

    next_edge("first", 3, 0, 0, 0, 0, 0);
    next_edge("m1", 10, 1, 10, 1, 0, 0);
    next_edge("m2", 10, 1, 10, 1, 0, 0);
    next_edge("m3_lock", 10, 1, 10, 1, 1, 0);
    next_edge("m13_break", 13, 1, 13, 0, 0, 0);
    next_edge("m9", 9, 1, 9, 1, 0, 0);
    next_edge("m11", 11, 1, 11, 1, 0, 0);
    next_edge("m10_relock", 10, 1, 10, 1, 1, 0);
    next_edge("m8_low", 8, 1, 8, 0, 0, 0);
    next_edge("m12_high", 12, 1, 12, 0, 0, 0);
    next_edge("r1", 10, 1, 10, 1, 0, 0);
    next_edge("r2", 10, 1, 10, 1, 0, 0);
    next_edge("r3", 10, 1, 10, 1, 1, 0);
    next_edge("sat", 10, 1, 10, 1, 1, 0);

    repeat (39) tick();
    check("los_pre.timeout", 32'(bus.timeout), 0);
    check("los_pre.locked",  32'(bus.locked),  1);
    tick();
    check("los.timeout", 32'(bus.timeout), 1);
    check("los.locked",  32'(bus.locked),  0);
    check("los.valid",   32'(bus.valid),   0);
    repeat (5) tick();
    check("los_sticky.timeout", 32'(bus.timeout), 1);
    next_edge("los_clear", 3, 0, 0, 0, 0, 0);
    next_edge("los_m1", 10, 1, 10, 1, 0, 0);
    next_edge("los_m2", 10, 1, 10, 1, 0, 0);
    next_edge("los_m3", 10, 1, 10, 1, 1, 0);

    repeat (2) tick();
    bus.start = 1'b0;
    tick();
    check("stop.locked",     32'(bus.locked),     0);
    check("stop.timeout",    32'(bus.timeout),    0);
    check("stop.valid",      32'(bus.valid),      0);
    check("stop.halfPeriod", 32'(bus.halfPeriod), 10);
    check("stop.inRange",    32'(bus.inRange),    1);
    bus.start = 1'b1;
    next_edge("restart_first", 3, 0, 0, 0, 0, 0);
    next_edge("restart_m1", 10, 1, 10, 1, 0, 0);
    next_edge("restart_m2", 10, 1, 10, 1, 0, 0);
    next_edge("restart_m3", 10, 1, 10, 1, 1, 0);

    repeat (2) tick();
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    bus.sigIn = 1'b0;
    tick();
    tick();
    check_all_zero("held_reset");
    reset = 1'b1;
    next_edge("post_reset_first", 3, 0, 0, 0, 0, 0);
    next_edge("post_reset_m1", 10, 1, 10, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
